// File: rtl/lcd_panel_model.sv
// lcd_panel_model: HD44780-style character panel, device side of the LCD bus.
// Ports: clk/rst; bus e/rs/rw/lcd_data -> lcd_data_out/lcd_data_oe;
//   busy plus config bits, addr/shift_offset, cmd_valid/cmd_dropped
//   pulses, dbg_addr/dbg_data combinational DDRAM peek.
module lcd_panel_model #(
    parameter int clk_freq   = 5,
    parameter int short_busy = 30 * clk_freq,
    parameter int long_busy  = 150 * clk_freq
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       display_lines,
    output logic       font,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_dec,
    output logic       shift,
    output logic [6:0] addr,
    output logic [6:0] shift_offset,
    output logic       cmd_valid,
    output logic       cmd_dropped,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam int CW = $clog2(long_busy + 1);
    localparam logic [CW-1:0] SHORT_N = CW'(short_busy - 1);
    localparam logic [CW-1:0] LONG_N  = CW'(long_busy - 1);
    localparam logic [6:0] LAST = 7'd79;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        CLEAR
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [6:0]    clr_q;
    logic [7:0]    mem_q [80];
    logic          e_q;
    logic          busy_q;
    logic          lines_q, font_q, don_q, cur_q, blink_q;
    logic          inc_q, shift_q;
    logic [6:0]    addr_q, ofs_q;
    logic          valid_q, drop_q;
    logic          oe_q;
    logic [7:0]    dout_q;

    logic wr_fall;
    logic rd_fall;

    // Bus lines are sampled at the same posedge that sees e fall.
    assign wr_fall = e_q & ~e & ~rw;
    assign rd_fall = e_q & ~e & rw;

    // Modulo-80 step used by addr and shift_offset alike.
    function automatic logic [6:0] step(input logic [6:0] a,
                                        input logic       up);
        if (up)
            return (a == LAST) ? 7'd0 : a + 7'd1;
        return (a == 7'd0) ? LAST : a - 7'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= LONG_N;
            clr_q   <= '0;
            e_q     <= 1'b0;
            busy_q  <= 1'b1;
            lines_q <= 1'b0;
            font_q  <= 1'b0;
            don_q   <= 1'b0;
            cur_q   <= 1'b0;
            blink_q <= 1'b0;
            inc_q   <= 1'b1;
            shift_q <= 1'b0;
            addr_q  <= '0;
            ofs_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            e_q     <= e;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            oe_q    <= e & rw;
            dout_q  <= 8'h00;
            if (e & rw)
                dout_q <= rs ? mem_q[addr_q] : {busy_q, addr_q};

            unique case (state_q)
                IDLE: begin
                    if (wr_fall) begin
                        valid_q <= 1'b1;
                        // Short busy unless the decode below overrides it.
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                        cnt_q   <= SHORT_N;
                        if (rs) begin
                            mem_q[addr_q] <= lcd_data;
                            addr_q <= step(addr_q, inc_q);
                            if (shift_q)
                                ofs_q <= step(ofs_q, inc_q);
                        end else begin
                            unique casez (lcd_data)
                                8'b1???????: begin
                                    addr_q <= (lcd_data[6:0] > LAST) ?
                                              7'd0 : lcd_data[6:0];
                                end
                                8'b01??????: begin
                                end
                                8'b001?????: begin
                                    lines_q <= lcd_data[3];
                                    font_q  <= lcd_data[2];
                                end
                                8'b0001????: begin
                                    if (lcd_data[3])
                                        ofs_q <= step(ofs_q, lcd_data[2]);
                                    else
                                        addr_q <= step(addr_q, lcd_data[2]);
                                end
                                8'b00001???: begin
                                    don_q   <= lcd_data[2];
                                    cur_q   <= lcd_data[1];
                                    blink_q <= lcd_data[0];
                                end
                                8'b000001??: begin
                                    inc_q   <= lcd_data[1];
                                    shift_q <= lcd_data[0];
                                end
                                8'b0000001?: begin
                                    addr_q <= '0;
                                    ofs_q  <= '0;
                                    cnt_q  <= LONG_N;
                                end
                                8'b00000001: begin
                                    addr_q  <= '0;
                                    ofs_q   <= '0;
                                    inc_q   <= 1'b1;
                                    cnt_q   <= LONG_N;
                                    clr_q   <= '0;
                                    state_q <= CLEAR;
                                end
                                default: begin
                                    busy_q  <= 1'b0;
                                    state_q <= IDLE;
                                end
                            endcase
                        end
                    end
                end
                BUSY, CLEAR: begin
                    // The 80-cycle fill always ends well inside long busy.
                    if (state_q == CLEAR) begin
                        mem_q[clr_q] <= 8'h20;
                        clr_q <= clr_q + 7'd1;
                        if (clr_q == LAST)
                            state_q <= BUSY;
                    end
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    if (wr_fall)
                        drop_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase

            if (rd_fall && rs)
                addr_q <= step(addr_q, inc_q);
        end
    end

    assign dbg_data = (dbg_addr <= LAST) ? mem_q[dbg_addr] : 8'h00;

    assign lcd_data_out  = dout_q;
    assign lcd_data_oe   = oe_q;
    assign busy          = busy_q;
    assign display_lines = lines_q;
    assign font          = font_q;
    assign display_on    = don_q;
    assign cursor_on     = cur_q;
    assign blink_on      = blink_q;
    assign inc_dec       = inc_q;
    assign shift         = shift_q;
    assign addr          = addr_q;
    assign shift_offset  = ofs_q;
    assign cmd_valid     = valid_q;
    assign cmd_dropped   = drop_q;

endmodule

// File: tb/tb_lcd_panel_model.sv
// tb_lcd_panel_model: self-checking bench for lcd_panel_model.
// Table of instruction writes plus hand sequences for timing corners.
module tb_lcd_panel_model;

    logic       clk = 1'b0;
    logic       rst;
    logic       e, rs, rw;
    logic [7:0] lcd_data;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic       busy;
    logic       display_lines, font, display_on, cursor_on, blink_on;
    logic       inc_dec, shift;
    logic [6:0] addr, shift_offset;
    logic       cmd_valid, cmd_dropped;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [6:0] cfg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lcd_panel_model dut (
        .clk(clk), .rst(rst), .e(e), .rs(rs), .rw(rw),
        .lcd_data(lcd_data), .lcd_data_out(lcd_data_out),
        .lcd_data_oe(lcd_data_oe), .busy(busy),
        .display_lines(display_lines), .font(font),
        .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .inc_dec(inc_dec), .shift(shift),
        .addr(addr), .shift_offset(shift_offset),
        .cmd_valid(cmd_valid), .cmd_dropped(cmd_dropped),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    assign cfg = {display_lines, font, display_on, cursor_on,
                  blink_on, inc_dec, shift};

    typedef struct {
        logic       rs;
        logic [7:0] d;
        logic [6:0] cfg;
        int         bz;
        string      nm;
    } vec_t;

    typedef struct {
        string      nm;
        logic [7:0] v;
    } sb_t;

    vec_t vt [8];
    sb_t  sb [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Falling edge of e lands on the third posedge after the call.
    task automatic pulse(input logic r, input logic [7:0] d);
        @(posedge clk); #1;
        rs = r; rw = 1'b0; lcd_data = d; e = 1'b1;
        @(posedge clk); #1;
        e = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic r, input logic [7:0] exp,
                            input string nm);
        sb_t s;
        sb.push_back('{nm, exp});
        @(posedge clk); #1;
        rs = r; rw = 1'b1; e = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_oe"}, lcd_data_oe, 1);
        if (sb.size() > 0) begin
            s = sb.pop_front();
            chk(s.nm, lcd_data_out, s.v);
        end
        e = 1'b0;
        @(posedge clk); #1;
        rw = 1'b0;
        chk({nm, "_oe_off"}, lcd_data_oe, 0);
        chk({nm, "_out_off"}, lcd_data_out, 0);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        measure_busy(n);
        if (n >= 2000) chk("busy_timeout", n, 0);
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] v);
        dbg_addr = a;
        #1;
        v = dbg_data;
    endtask

    task automatic scan_spaces(input string nm);
        int bad;
        logic [7:0] v;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            peek(7'(i), v);
            if (v !== 8'h20) bad++;
        end
        chk(nm, bad, 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (cmd_valid && cmd_dropped) begin
            fails++;
            $display("FAIL pulse_overlap: valid=1 dropped=1 required not both");
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] v;

        vt[0] = '{1'b0, 8'h38, 7'b1000010, 150, "fset_38"};
        vt[1] = '{1'b0, 8'h0E, 7'b1011010, 150, "dctl_0e"};
        vt[2] = '{1'b0, 8'h06, 7'b1011010, 150, "entry_06"};
        vt[3] = '{1'b0, 8'h34, 7'b0111010, 150, "fset_34"};
        vt[4] = '{1'b0, 8'h0F, 7'b0111110, 150, "dctl_0f"};
        vt[5] = '{1'b0, 8'h38, 7'b1011110, 150, "fset_38b"};
        vt[6] = '{1'b0, 8'h40, 7'b1011110, 150, "cgram_40"};
        vt[7] = '{1'b0, 8'h00, 7'b1011110, 0,   "nop_00"};

        rst = 1'b1; e = 1'b0; rs = 1'b0; rw = 1'b0;
        lcd_data = 8'h00; dbg_addr = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_cfg", cfg, 7'b0000010);
        chk("rst_addr", addr, 0);
        chk("rst_ofs", shift_offset, 0);
        chk("rst_oe", lcd_data_oe, 0);
        chk("rst_out", lcd_data_out, 0);
        chk("rst_pulses", {cmd_valid, cmd_dropped}, 0);
        rst = 1'b0;
        measure_busy(n);
        chk("rst_busy_len", n, 750);
        scan_spaces("rst_fill");
        chk("post_rst_addr", addr, 0);
        chk("post_rst_inc", inc_dec, 1);
        peek(7'd80, v);
        chk("dbg_oob", v, 8'h00);
        bus_read(1'b0, 8'h00, "status_idle");

        for (int i = 0; i < 8; i++) begin
            pulse(vt[i].rs, vt[i].d);
            chk({vt[i].nm, "_valid"}, cmd_valid, 1);
            chk({vt[i].nm, "_cfg"}, cfg, vt[i].cfg);
            measure_busy(n);
            chk({vt[i].nm, "_busy"}, n, vt[i].bz);
            repeat (200 - n) @(posedge clk);
            #1;
        end

        pulse(1'b0, 8'hCF);
        chk("setaddr_79", addr, 79);
        wait_idle();
        pulse(1'b1, 8'h41);
        peek(7'd79, v);
        chk("wr79_data", v, 8'h41);
        chk("wr79_wrap", addr, 0);
        wait_idle();
        pulse(1'b0, 8'h04);
        wait_idle();
        pulse(1'b1, 8'h42);
        peek(7'd0, v);
        chk("wr0_data", v, 8'h42);
        chk("wr0_wrap", addr, 79);
        wait_idle();

        pulse(1'b1, 8'h55);
        chk("wr55_addr", addr, 78);
        pulse(1'b1, 8'h66);
        chk("drop_pulse", {cmd_dropped, cmd_valid}, 2'b10);
        chk("drop_addr", addr, 78);
        peek(7'd78, v);
        chk("drop_mem", v, 8'h20);
        bus_read(1'b0, 8'hCE, "status_busy");
        wait_idle();
        bus_read(1'b1, 8'h20, "data_rd78");
        chk("rd_step", addr, 77);

        pulse(1'b0, 8'h06);
        chk("entry06_valid", cmd_valid, 1);
        repeat (147) @(posedge clk);
        #1;
        pulse(1'b0, 8'h07);
        chk("edge_fall_drop", cmd_dropped, 1);
        chk("edge_fall_shift", shift, 0);
        chk("edge_fall_busy", busy, 0);
        pulse(1'b0, 8'h07);
        chk("after_fall_ok", {cmd_valid, shift}, 2'b11);
        wait_idle();

        pulse(1'b0, 8'h85);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 8'(8'h61 + i));
            wait_idle();
        end
        chk("dshift_ofs3", shift_offset, 3);
        chk("dshift_addr8", addr, 8);
        peek(7'd7, v);
        chk("dshift_mem7", v, 8'h63);
        pulse(1'b0, 8'h02);
        chk("home_addr", addr, 0);
        chk("home_ofs", shift_offset, 0);
        measure_busy(n);
        chk("home_busy", n, 750);
        pulse(1'b0, 8'h18);
        chk("shl_wrap", shift_offset, 79);
        wait_idle();
        pulse(1'b0, 8'h1C);
        chk("shr_wrap", shift_offset, 0);
        wait_idle();
        pulse(1'b0, 8'h10);
        chk("curl_wrap", addr, 79);
        wait_idle();
        pulse(1'b0, 8'h14);
        chk("curr_wrap", addr, 0);
        wait_idle();

        pulse(1'b0, 8'h01);
        chk("clr_valid", cmd_valid, 1);
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        measure_busy(n);
        chk("clr_rst_busy", n, 750);
        scan_spaces("clr_rst_fill");
        chk("clr_rst_addr", addr, 0);
        chk("clr_rst_ofs", shift_offset, 0);
        chk("clr_rst_cfg", cfg, 7'b0000010);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_panel_model.md
# lcd_panel_model

Cycle-accurate HD44780-style character panel responder: the device end of the 4-wire-control / 8-bit-data LCD bus driven by the team's LCD controller. Samples `e`, `rs`, `rw`, `lcd_data`, commits instructions and data writes on the falling edge of `e`, maintains display configuration, the DDRAM address counter and a display-shift offset, and drives status/data on reads. Used as the bus partner in controller testbenches and as an on-FPGA loopback target.

## Interface
- `clk_freq`, 5: clock cycles per busy-time unit.
- `short_busy`, 30*clk_freq: busy cycles after any write except clear/home.
- `long_busy`, 150*clk_freq: busy cycles after clear, return-home and reset.
- `clk` input 1: sole clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `e` input 1: bus enable strobe.
- `rs` input 1: 0 = instruction/status, 1 = data.
- `rw` input 1: 0 = write, 1 = read.
- `lcd_data` input 8: write data from the controller.
- `lcd_data_out` output 8: read data to the controller.
- `lcd_data_oe` output 1: high while `lcd_data_out` is valid.
- `busy` output 1: busy flag.
- `display_lines`, `font`, `display_on`, `cursor_on`, `blink_on`, `inc_dec`, `shift` outputs 1 each: configuration bits.
- `addr` output 7: DDRAM address counter, 0..79.
- `shift_offset` output 7: display-shift offset, 0..79.
- `cmd_valid` output 1: one-cycle pulse, write accepted.
- `cmd_dropped` output 1: one-cycle pulse, write ignored because busy.
- `dbg_addr` input 7 / `dbg_data` output 8: combinational DDRAM peek; `dbg_addr` ≥ 80 returns 0x00.

## Operation
- `e_d` = `e` registered. Falling edge = `e_d`=1 and `e`=0 at a posedge; `rs`, `rw`, `lcd_data` sampled at that same posedge.
- DDRAM: 80 × 8 bits. Address arithmetic mod 80 (79+1→0, 0−1→79); same for `shift_offset`.
- Write falling edge with `busy`=1: no state change, `cmd_dropped` pulses. Otherwise decode by highest set bit (rs=0, rw=0):
  - 1aaaaaaa: `addr`=a (a ≥ 80 loads 0). Short busy.
  - 01xxxxxx: CGRAM address, accepted, no effect. Short busy.
  - 001xNFxx: `display_lines`=N, `font`=F. Short busy.
  - 0001SRxx: S=0 moves `addr`, S=1 moves `shift_offset`; R=1 +1, R=0 −1. Short busy.
  - 00001DCB: `display_on`, `cursor_on`, `blink_on`. Short busy.
  - 000001IS: `inc_dec`=I, `shift`=S. Short busy.
  - 0000001x: return home: `addr`=0, `shift_offset`=0. Long busy.
  - 00000001: clear: DDRAM filled with 0x20, `addr`=0, `shift_offset`=0, `inc_dec`=1. Long busy.
  - 00000000: no-op, no busy, `cmd_valid` still pulses.
- Data write (rs=1, rw=0): DDRAM[`addr`]=data, then `addr` ±1 per `inc_dec`; if `shift`=1, `shift_offset` steps in the same direction. Short busy.
- Reads never dropped, allowed while busy. rs=0: `lcd_data_out`={`busy`, `addr`}. rs=1: DDRAM[`addr`]; on its falling edge `addr` steps per `inc_dec` (no shift, no busy).
- States: IDLE (busy=0), BUSY (counter running), CLEAR (fill pass, one address/cycle, 80 cycles, runs inside the long-busy window).

## Timing
- Reset: all outputs 0 except `inc_dec`=1, `busy`=1; enters CLEAR with long busy. A write edge during reset is lost; `rst` mid-operation restarts the clear and busy counter.
- Write committed at the falling-edge posedge; config/`addr` visible and `cmd_valid` high the next cycle; `busy` rises that same next cycle and stays high exactly `short_busy` or `long_busy` cycles.
- `lcd_data_oe` = registered (`e` & `rw`); `lcd_data_out` registered, one-cycle latency from `e` rising; 0x00 when `lcd_data_oe`=0.
- Write edge in the cycle `busy` falls (counter at last cycle): dropped. First accepted edge is the cycle after `busy`=0.
- `cmd_valid` and `cmd_dropped` never high together.

## Test plan
- Reset → `busy`=1 for 750 cycles; then DDRAM all 0x20, `addr`=0, `inc_dec`=1, status read returns 0x00.
- Write 0x38, 0x0E, 0x06 spaced 200 cycles → `display_lines`=1, `font`=0, `display_on`=1, `cursor_on`=1, `blink_on`=0, `inc_dec`=1; each `busy` exactly 150 cycles.
- Set addr 0xCF (=79), data write 0x41 → DDRAM[79]=0x41, `addr` wraps to 0; entry mode 0x04, write 0x42 at 0 → `addr`=79.
- Second write within 150 cycles of a data write → `cmd_dropped` pulse, DDRAM/`addr` unchanged; status read during busy returns bit7=1.
- Entry 0x07, three data writes → `shift_offset`=3; write 0x02 → `addr`=0, `shift_offset`=0, `busy` 750 cycles.
- Clear (0x01) interrupted by `rst` at cycle 40 → full clear restarts, `busy` 750 cycles from reset release.
